// File: rtl/sdr_lib.sv
// Shared SDR receive-path definitions: rssi-path widths, AGC defaults and state encoding.
// Latency: none, declarations only.
// Backpressure: not applicable.
package sdr_lib;

  // Width of the averaged magnitude / clip-density words from the RSSI stage
  localparam int RSSI_W = 16;

  // Width of the AGC settle hold-off counter (matches settle_cycles)
  localparam int AGC_CNT_W = 16;

  // Default gain step taken on ADC overload
  localparam int AGC_ATTACK_DEF = 4;

  // Width of the gain-update counter
  localparam int AGC_CHG_W = 16;

  typedef enum logic [1:0] {
    AGC_IDLE     = 2'd0,
    AGC_WAIT_ACK = 2'd1,
    AGC_SETTLE   = 2'd2,
    AGC_EVAL     = 2'd3
  } agc_state_e;

endpackage

// File: rtl/rx_agc_ctrl_if.sv
// Gain-update handshake between the AGC controller and the analog front end.
// Latency: wires only.
// Backpressure: gain_stb is held with gain stable until the front end returns gain_ack.
interface rx_agc_ctrl_if #(
  parameter int GW = 6
);
  logic [GW-1:0] gain;
  logic          gain_stb;
  logic          gain_ack;

  // AGC side drives the code and strobe, front end answers with ack
  modport master (output gain, output gain_stb, input gain_ack);
  modport slave  (input gain, input gain_stb, output gain_ack);
endinterface

// File: rtl/agc_holdoff_ctr.sv
// Settle hold-off down-counter: load a cycle count, step it down, flag when empty.
// Latency: load/dec take effect on the next edge; zero is combinational from the count.
// Backpressure: none; dec at zero is ignored so the count never wraps.
module agc_holdoff_ctr
  import sdr_lib::*;
#(
  parameter int W = AGC_CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Clear beats load, load beats decrement
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rx_agc_ctrl.sv
// Receive AGC loop: steps the front-end gain code from rssi / clip density with settle hold-off.
// Latency: one cycle from EVAL input sampling to the gain / gain_stb update.
// Backpressure: each new gain is strobed and held until gain_ack; no decision is taken meanwhile.
module rx_agc_ctrl
  import sdr_lib::*;
#(
  parameter int GW     = 6,
  parameter int ATTACK = AGC_ATTACK_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [RSSI_W-1:0]    rssi,
  input  logic [RSSI_W-1:0]    over_count,
  input  logic [RSSI_W-1:0]    thresh_hi,
  input  logic [RSSI_W-1:0]    thresh_lo,
  input  logic [RSSI_W-1:0]    over_thresh,
  input  logic [AGC_CNT_W-1:0] settle_cycles,
  input  logic [GW-1:0]        gain_max,
  rx_agc_ctrl_if.master        fe,
  output logic [1:0]           agc_state,
  output logic [AGC_CHG_W-1:0] changes
);

  // Gain arithmetic is one bit wider than the code so steps cannot wrap
  localparam logic [GW:0] ATTACK_X = (GW+1)'(ATTACK);
  localparam logic [GW:0] ONE_X    = (GW+1)'(1);

  agc_state_e           state;
  logic [GW-1:0]        gain_r;
  logic                 stb_r;
  logic [AGC_CHG_W-1:0] changes_r;
  logic [AGC_CHG_W-1:0] changes_inc;

  logic [GW:0] gain_x;
  logic [GW:0] max_x;
  logic [GW:0] rule_x;
  logic [GW:0] target_x;

  logic hold_zero;
  logic hold_load;
  logic hold_dec;

  assign gain_x = {1'b0, gain_r};
  assign max_x  = {1'b0, gain_max};

  // Gain rule in priority order, then clamp to gain_max (also covers gain_max lowered under gain)
  always_comb begin
    rule_x = gain_x;
    if (over_count > over_thresh) begin
      rule_x = (gain_x > ATTACK_X) ? (gain_x - ATTACK_X) : '0;
    end else if (rssi > thresh_hi) begin
      rule_x = (gain_x != '0) ? (gain_x - ONE_X) : '0;
    end else if (rssi < thresh_lo) begin
      rule_x = gain_x + ONE_X;
    end
    target_x = (rule_x > max_x) ? max_x : rule_x;
  end

  assign changes_inc = (changes_r == {AGC_CHG_W{1'b1}}) ? changes_r : (changes_r + 1'b1);

  // Settle counter loads on the acknowledged edge and runs down only while settling
  assign hold_load = enable && (state == AGC_WAIT_ACK) && fe.gain_ack;
  assign hold_dec  = enable && (state == AGC_SETTLE) && !hold_zero;

  agc_holdoff_ctr #(
    .W (AGC_CNT_W)
  ) u_holdoff (
    .clock    (clock),
    .reset    (reset),
    .clear    (!enable),
    .load     (hold_load),
    .dec      (hold_dec),
    .load_val (settle_cycles),
    .zero     (hold_zero)
  );

  // AGC state machine with registered gain, strobe and update count
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= AGC_IDLE;
      gain_r    <= '0;
      stb_r     <= 1'b0;
      changes_r <= '0;
    end else if (!enable) begin
      state <= AGC_IDLE;
      stb_r <= 1'b0;
    end else begin
      case (state)
        AGC_IDLE: begin
          // gain_max is GW bits wide, so it never exceeds the top legal code
          gain_r    <= gain_max;
          stb_r     <= 1'b1;
          changes_r <= changes_inc;
          state     <= AGC_WAIT_ACK;
        end
        AGC_WAIT_ACK: begin
          if (fe.gain_ack) begin
            stb_r <= 1'b0;
            state <= AGC_SETTLE;
          end
        end
        AGC_SETTLE: begin
          if (hold_zero) begin
            state <= AGC_EVAL;
          end
        end
        AGC_EVAL: begin
          if (target_x != gain_x) begin
            gain_r    <= target_x[GW-1:0];
            stb_r     <= 1'b1;
            changes_r <= changes_inc;
            state     <= AGC_WAIT_ACK;
          end
        end
        default: state <= AGC_IDLE;
      endcase
    end
  end

  assign fe.gain     = gain_r;
  assign fe.gain_stb = stb_r;
  assign agc_state   = state;
  assign changes     = changes_r;

endmodule

// File: tb/tb_rx_agc_ctrl.sv
module tb_rx_agc_ctrl;
  localparam int GW      = 6;
  localparam int ATTACK  = 4;
  localparam int S_IDLE  = 0;
  localparam int S_WAIT  = 1;
  localparam int S_SETTL = 2;
  localparam int S_EVAL  = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [15:0]   rssi, over_count, thresh_hi, thresh_lo, over_thresh, settle_cycles;
  logic [GW-1:0] gain_max;
  logic [1:0]    agc_state;
  logic [15:0]   changes;

  int checks = 0;
  int errors = 0;
  int model_changes = 0;

  rx_agc_ctrl_if #(.GW(GW)) fe_if ();

  rx_agc_ctrl #(.GW(GW), .ATTACK(ATTACK)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .rssi          (rssi),
    .over_count    (over_count),
    .thresh_hi     (thresh_hi),
    .thresh_lo     (thresh_lo),
    .over_thresh   (over_thresh),
    .settle_cycles (settle_cycles),
    .gain_max      (gain_max),
    .fe            (fe_if),
    .agc_state     (agc_state),
    .changes       (changes)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Reference gain decision taken directly from the rule list, in plain integers
  function automatic int ref_target(int g, int gmax, int r, int oc, int hi, int lo, int ot);
    int t;
    if (oc > ot)      t = (g - ATTACK < 0) ? 0 : g - ATTACK;
    else if (r > hi)  t = (g == 0) ? 0 : g - 1;
    else if (r < lo)  t = g + 1;
    else              t = g;
    if (t > gmax) t = gmax;
    return t;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_ack(input int delay);
    repeat (delay) tick();
    fe_if.gain_ack = 1'b1;
    tick();
    fe_if.gain_ack = 1'b0;
  endtask

  task automatic count_settle(output int n);
    n = 0;
    while (agc_state == 2'(S_SETTL) && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_state(input int s, output bit ok);
    int k = 0;
    while (agc_state != 2'(s) && k < 200) begin
      k++;
      tick();
    end
    ok = (agc_state == 2'(s));
  endtask

  task automatic set_inband();
    rssi = 16'd300; thresh_lo = 16'd200; thresh_hi = 16'd400;
    over_count = 16'd100; over_thresh = 16'd500;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; fe_if.gain_ack = 1'b0;
    set_inband(); settle_cycles = 16'd4; gain_max = 6'd40;
    tick(); tick();
    checks++; if (agc_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", agc_state); end
    checks++; if (fe_if.gain !== 6'd0) begin errors++; $display("FAIL reset_gain: got %0d expected 0", fe_if.gain); end
    checks++; if (fe_if.gain_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %0b expected 0", fe_if.gain_stb); end
    checks++; if (changes !== 16'd0) begin errors++; $display("FAIL reset_changes: got %0d expected 0", changes); end
    enable = 1'b0; reset = 1'b0;
    tick();
    checks++; if (agc_state !== 2'd0 || fe_if.gain_stb !== 1'b0) begin errors++; $display("FAIL idle_disabled: state %0d stb %0b expected 0/0", agc_state, fe_if.gain_stb); end
  endtask

  task automatic test_powerup();
    int stb_hi = 0;
    int n;
    fe_if.gain_ack = 1'b1;   // ack while still idle must be ignored
    enable = 1'b1;
    tick();
    fe_if.gain_ack = 1'b0;
    model_changes = 1;
    checks++; if (agc_state !== 2'(S_WAIT) || fe_if.gain !== 6'd40 || changes !== 16'd1) begin errors++; $display("FAIL powerup_load: state %0d gain %0d changes %0d expected 1/40/1", agc_state, fe_if.gain, changes); end
    for (int i = 0; i < 3; i++) begin
      if (fe_if.gain_stb === 1'b1) stb_hi++;
      if (i == 2) fe_if.gain_ack = 1'b1;
      tick();
    end
    fe_if.gain_ack = 1'b0;
    checks++; if (stb_hi != 3 || fe_if.gain_stb !== 1'b0) begin errors++; $display("FAIL powerup_stb_len: high %0d cycles stb now %0b expected 3/0", stb_hi, fe_if.gain_stb); end
    checks++; if (agc_state !== 2'(S_SETTL)) begin errors++; $display("FAIL powerup_settle: state %0d expected 2", agc_state); end
    count_settle(n);
    checks++; if (n != 5 || agc_state !== 2'(S_EVAL)) begin errors++; $display("FAIL powerup_settle_len: %0d cycles state %0d expected 5/3", n, agc_state); end
  endtask

  task automatic test_overload();
    int exp_g = 40;
    int n;
    int bad = 0;
    bit ok;
    over_count = 16'd900; over_thresh = 16'd500; rssi = 16'd450; thresh_hi = 16'd400;
    settle_cycles = 16'd0;
    while (exp_g > 0) begin
      exp_g = (exp_g - ATTACK < 0) ? 0 : exp_g - ATTACK;
      model_changes++;
      wait_state(S_WAIT, ok);
      checks++; if (!ok || fe_if.gain !== 6'(exp_g) || changes !== 16'(model_changes)) begin errors++; $display("FAIL overload_step: reached %0b gain %0d changes %0d expected gain %0d changes %0d", ok, fe_if.gain, changes, exp_g, model_changes); end
      do_ack(0);
      count_settle(n);
    end
    checks++; if (n != 1) begin errors++; $display("FAIL overload_settle0: %0d cycles expected 1", n); end
    repeat (8) begin
      if (fe_if.gain_stb !== 1'b0 || fe_if.gain !== 6'd0 || agc_state !== 2'(S_EVAL)) bad++;
      tick();
    end
    checks++; if (bad != 0 || changes !== 16'(model_changes)) begin errors++; $display("FAIL overload_floor: %0d bad cycles changes %0d expected 0/%0d", bad, changes, model_changes); end
  endtask

  task automatic test_low_signal();
    int n;
    int bad = 0;
    bit ok;
    set_inband();
    rssi = 16'd100; thresh_lo = 16'd200; settle_cycles = 16'd10;
    enable = 1'b0; tick();
    gain_max = 6'd38; enable = 1'b1; tick();
    model_changes++;
    checks++; if (fe_if.gain !== 6'd38 || agc_state !== 2'(S_WAIT)) begin errors++; $display("FAIL low_start: gain %0d state %0d expected 38/1", fe_if.gain, agc_state); end
    gain_max = 6'd40;
    do_ack(1);
    count_settle(n);
    checks++; if (n != 11) begin errors++; $display("FAIL low_settle_a: %0d cycles expected 11", n); end
    for (int step = 39; step <= 40; step++) begin
      model_changes++;
      wait_state(S_WAIT, ok);
      checks++; if (!ok || fe_if.gain !== 6'(step) || changes !== 16'(model_changes)) begin errors++; $display("FAIL low_step: gain %0d changes %0d expected %0d/%0d", fe_if.gain, changes, step, model_changes); end
      do_ack(0);
      count_settle(n);
      checks++; if (n != 11) begin errors++; $display("FAIL low_settle_b: %0d cycles expected 11", n); end
    end
    repeat (20) begin
      if (fe_if.gain_stb !== 1'b0 || fe_if.gain !== 6'd40) bad++;
      tick();
    end
    checks++; if (bad != 0 || changes !== 16'(model_changes)) begin errors++; $display("FAIL low_cap: %0d bad cycles changes %0d expected 0/%0d", bad, changes, model_changes); end
  endtask

  task automatic test_inband();
    int bad = 0;
    set_inband();
    repeat (1000) begin
      if (agc_state !== 2'(S_EVAL) || fe_if.gain_stb !== 1'b0 || fe_if.gain !== 6'd40) bad++;
      tick();
    end
    checks++; if (bad != 0 || changes !== 16'(model_changes)) begin errors++; $display("FAIL inband_hold: %0d bad cycles changes %0d expected 0/%0d", bad, changes, model_changes); end
  endtask

  task automatic test_gain_max_lower();
    gain_max = 6'd33;
    tick();
    model_changes++;
    checks++; if (agc_state !== 2'(S_WAIT) || fe_if.gain !== 6'd33 || fe_if.gain_stb !== 1'b1 || changes !== 16'(model_changes)) begin errors++; $display("FAIL gmax_lower: state %0d gain %0d stb %0b changes %0d expected 1/33/1/%0d", agc_state, fe_if.gain, fe_if.gain_stb, changes, model_changes); end
  endtask

  task automatic test_abort();
    enable = 1'b0;
    tick();
    checks++; if (agc_state !== 2'(S_IDLE) || fe_if.gain_stb !== 1'b0 || fe_if.gain !== 6'd33 || changes !== 16'(model_changes)) begin errors++; $display("FAIL abort_idle: state %0d stb %0b gain %0d changes %0d expected 0/0/33/%0d", agc_state, fe_if.gain_stb, fe_if.gain, changes, model_changes); end
    fe_if.gain_ack = 1'b1;
    tick(); tick();
    fe_if.gain_ack = 1'b0;
    checks++; if (agc_state !== 2'(S_IDLE) || fe_if.gain !== 6'd33 || changes !== 16'(model_changes)) begin errors++; $display("FAIL abort_late_ack: state %0d gain %0d changes %0d expected 0/33/%0d", agc_state, fe_if.gain, changes, model_changes); end
  endtask

  task automatic test_midreset();
    gain_max = 6'd40; settle_cycles = 16'd50;
    enable = 1'b1; tick();
    do_ack(0);
    tick(); tick();
    checks++; if (agc_state !== 2'(S_SETTL)) begin errors++; $display("FAIL midreset_pre: state %0d expected 2", agc_state); end
    reset = 1'b1;
    tick();
    checks++; if (agc_state !== 2'd0 || fe_if.gain !== 6'd0 || fe_if.gain_stb !== 1'b0 || changes !== 16'd0) begin errors++; $display("FAIL midreset_vals: state %0d gain %0d stb %0b changes %0d expected all 0", agc_state, fe_if.gain, fe_if.gain_stb, changes); end
    reset = 1'b0; enable = 1'b0;
    model_changes = 0;
    tick();
  endtask

  task automatic test_random();
    int model_gain;
    int exp_g;
    int n;
    int sc;
    bit ok;
    set_inband();
    gain_max = 6'($urandom_range(8, 63));
    settle_cycles = 16'($urandom_range(0, 3));
    enable = 1'b1; tick();
    model_gain = int'(gain_max);
    model_changes = 1;
    do_ack(0);
    count_settle(n);
    for (int it = 0; it < 60; it++) begin
      wait_state(S_EVAL, ok);
      rssi        = 16'($urandom_range(0, 600));
      thresh_lo   = 16'($urandom_range(100, 300));
      thresh_hi   = 16'($urandom_range(300, 500));
      over_count  = 16'($urandom_range(0, 1000));
      over_thresh = 16'($urandom_range(500, 1000));
      if ($urandom_range(0, 7) == 0) gain_max = 6'($urandom_range(0, 63));
      sc = $urandom_range(0, 6);
      settle_cycles = 16'(sc);
      exp_g = ref_target(model_gain, int'(gain_max), int'(rssi), int'(over_count),
                         int'(thresh_hi), int'(thresh_lo), int'(over_thresh));
      tick();
      if (exp_g != model_gain) begin
        model_changes++;
        checks++; if (!ok || agc_state !== 2'(S_WAIT) || fe_if.gain !== 6'(exp_g) || fe_if.gain_stb !== 1'b1 || changes !== 16'(model_changes)) begin errors++; $display("FAIL rand_change it%0d: state %0d gain %0d stb %0b changes %0d expected 1/%0d/1/%0d", it, agc_state, fe_if.gain, fe_if.gain_stb, changes, exp_g, model_changes); end
        do_ack($urandom_range(0, 3));
        count_settle(n);
        checks++; if (n != sc + 1) begin errors++; $display("FAIL rand_settle it%0d: %0d cycles expected %0d", it, n, sc + 1); end
        model_gain = exp_g;
      end else begin
        checks++; if (!ok || agc_state !== 2'(S_EVAL) || fe_if.gain !== 6'(model_gain) || fe_if.gain_stb !== 1'b0 || changes !== 16'(model_changes)) begin errors++; $display("FAIL rand_hold it%0d: state %0d gain %0d stb %0b changes %0d expected 3/%0d/0/%0d", it, agc_state, fe_if.gain, fe_if.gain_stb, changes, model_gain, model_changes); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_overload();
    test_low_signal();
    test_inband();
    test_gain_max_lower();
    test_abort();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
